// File: rtl/boolean_lut_engine.sv
// ---------------------------------------------------------------------------
// boolean_lut_engine
//
// Purpose:
//   Holds N_OUT runtime-loadable truth tables over N_IN Boolean inputs.
//   Evaluates one input vector on request, or runs an exhaustive sweep over
//   all 2**N_IN input combinations, one result per cycle. All results come
//   from registers.
//
// Optional feature (macro SWEEP_SIG_EN):
//   When defined, a 16-bit MISR (x^16+x^12+x^5+1) compacts the sweep results
//   into the 'sig' output. It is seeded to 16'hFFFF when a sweep is accepted.
//   When undefined, neither the port nor the logic exists.
//
// Ports:
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   cfg_valid     truth-table write request
//   cfg_ready     high when a write can be accepted (IDLE only)
//   cfg_sel       function index to write (>= N_OUT: accepted, discarded)
//   cfg_table     truth table, bit k = function value for input index k
//   in_valid      evaluate request for in_vec
//   in_vec        input index, MSB is in_vec[N_IN-1]
//   sweep_start   start exhaustive sweep
//   sweep_busy    high while sweep results are being produced
//   sweep_done    one-cycle pulse with the last sweep result
//   out_valid     one-cycle pulse, out_idx/out_vec valid
//   out_idx       input index that produced out_vec
//   out_vec       out_vec[j] = table[j][out_idx]
//   sig           MISR signature (SWEEP_SIG_EN only)
//   dbg_state     current FSM state (0 = IDLE, 1 = SWEEP)
//
// Handshake: a request is taken on the rising edge where its valid is high
// and the engine is in IDLE. cfg_ready reports IDLE. In IDLE, a cfg write
// beats sweep_start, which beats in_valid. Losing requests are dropped, not
// queued. In SWEEP, every request is ignored.
// ---------------------------------------------------------------------------
module boolean_lut_engine #(
    parameter int N_IN  = 3,
    parameter int N_OUT = 3,
    localparam int TT_W  = 2 ** N_IN,
    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [TT_W-1:0]  cfg_table,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    output logic [N_IN-1:0]  out_idx,
    output logic [N_OUT-1:0] out_vec,
`ifdef SWEEP_SIG_EN
    output logic [15:0]      sig,
`endif
    output logic             dbg_state
);

    typedef enum logic {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

    localparam logic [N_IN:0] CNT_LAST = (N_IN + 1)'(TT_W - 1);

    state_t             state_q, state_d;
    // One bit wider than an index so the terminal compare never aliases.
    logic [N_IN:0]      cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [N_IN-1:0]    out_idx_q, out_idx_d;
    logic [N_OUT-1:0]   out_vec_q, out_vec_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [TT_W-1:0]    tbl_q [N_OUT];

    logic               cfg_acc, sweep_acc, eval_acc;
    logic [N_IN-1:0]    look_idx;
    logic [N_OUT-1:0]   look_vec;

    assign cfg_ready = (state_q == S_IDLE);
    assign cfg_acc   = cfg_valid & cfg_ready;
    assign sweep_acc = sweep_start & cfg_ready & ~cfg_valid;
    assign eval_acc  = in_valid & cfg_ready & ~cfg_valid & ~sweep_start;

    // The sweep counter owns the lookup while sweeping. Otherwise in_vec does.
    assign look_idx = (state_q == S_SWEEP) ? cnt_q[N_IN-1:0] : in_vec;

    always_comb begin
        look_vec = '0;
        for (int j = 0; j < N_OUT; j++) begin
            look_vec[j] = tbl_q[j][look_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_idx_d   = out_idx_q;
        out_vec_d   = out_vec_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        if (state_q == S_IDLE) begin
            if (sweep_acc) begin
                state_d = S_SWEEP;
                cnt_d   = '0;
            end else if (eval_acc) begin
                out_valid_d = 1'b1;
                out_idx_d   = in_vec;
                out_vec_d   = look_vec;
            end
        end else begin
            out_valid_d = 1'b1;
            out_idx_d   = cnt_q[N_IN-1:0];
            out_vec_d   = look_vec;
            busy_d      = 1'b1;
            if (cnt_q == CNT_LAST) begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_vec_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_vec_q   <= out_vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // An out-of-range cfg_sel matches no entry, so the write is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < N_OUT; j++) begin
                tbl_q[j] <= '0;
            end
        end else if (cfg_acc) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (cfg_sel == SEL_W'(j)) begin
                    tbl_q[j] <= cfg_table;
                end
            end
        end
    end

`ifdef SWEEP_SIG_EN
    logic [15:0] sig_q, sig_d;
    logic        sig_fb;

    assign sig_fb = sig_q[15] ^ sig_q[11] ^ sig_q[4];

    always_comb begin
        sig_d = sig_q;
        if (sweep_acc) begin
            sig_d = 16'hFFFF;
        end else if (state_q == S_SWEEP) begin
            sig_d = {sig_q[14:0], sig_fb} ^ {{(16 - N_OUT){1'b0}}, look_vec};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 16'h0000;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig = sig_q;
`endif

    assign sweep_busy = busy_q;
    assign sweep_done = done_q;
    assign out_valid  = out_valid_q;
    assign out_idx    = out_idx_q;
    assign out_vec    = out_vec_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_boolean_lut_engine.sv
// ---------------------------------------------------------------------------
// tb_boolean_lut_engine
//
// Directed testbench for boolean_lut_engine with N_IN = 3 and N_OUT = 3.
// Inputs are driven, and outputs sampled, 1 time unit after each rising edge.
// Expected values are hand-computed constants for these tables:
//   table0 = 8'hE8 (majority)
//   table1 = 8'h96 (xor3)
//   table2 = 8'h80 (and3)
// ---------------------------------------------------------------------------
module tb_boolean_lut_engine;

    localparam int N_IN  = 3;
    localparam int N_OUT = 3;
    localparam int TT_W  = 8;
    localparam int SEL_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cfg_valid = 1'b0;
    logic             cfg_ready;
    logic [SEL_W-1:0] cfg_sel = '0;
    logic [TT_W-1:0]  cfg_table = '0;
    logic             in_valid = 1'b0;
    logic [N_IN-1:0]  in_vec = '0;
    logic             sweep_start = 1'b0;
    logic             sweep_busy;
    logic             sweep_done;
    logic             out_valid;
    logic [N_IN-1:0]  out_idx;
    logic [N_OUT-1:0] out_vec;
    logic             dbg_state;
`ifdef SWEEP_SIG_EN
    logic [15:0]      sig;
    logic [15:0]      sig_first;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [N_OUT-1:0] exp_q[$];

    boolean_lut_engine #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_sel     (cfg_sel),
        .cfg_table   (cfg_table),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_vec     (out_vec),
`ifdef SWEEP_SIG_EN
        .sig         (sig),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [SEL_W-1:0] sel, input logic [TT_W-1:0] tbl);
        cfg_valid = 1'b1;
        cfg_sel   = sel;
        cfg_table = tbl;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic eval(input string tag, input logic [N_IN-1:0] v, input logic [N_OUT-1:0] exp);
        in_valid = 1'b1;
        in_vec   = v;
        tick();
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_idx"}, out_idx, v);
        check({tag, "_vec"}, out_vec, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"}, sweep_busy, 1'b0);
        check({tag, "_done"}, sweep_done, 1'b0);
        check({tag, "_idx"}, out_idx, 3'd0);
        check({tag, "_vec"}, out_vec, 3'd0);
        check({tag, "_ready"}, cfg_ready, 1'b1);
`ifdef SWEEP_SIG_EN
        check({tag, "_sig"}, sig, 16'h0000);
`endif
    endtask

`ifdef SWEEP_SIG_EN
    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [N_OUT-1:0] v);
        logic fb;
        fb = s[15] ^ s[11] ^ s[4];
        return {s[14:0], fb} ^ {13'b0, v};
    endfunction
`endif

    // Full sweep with the standard tables. With noisy set, write, eval and
    // sweep requests are held high throughout the sweep.
    task automatic run_sweep(input string tag, input bit noisy);
        logic [N_OUT-1:0] seq [8];
        logic [N_OUT-1:0] exp_v;
`ifdef SWEEP_SIG_EN
        logic [15:0] sig_exp;
        sig_exp = 16'hFFFF;
`endif
        seq = '{3'b000, 3'b010, 3'b010, 3'b001, 3'b010, 3'b001, 3'b001, 3'b111};
        for (int i = 0; i < 8; i++) exp_q.push_back(seq[i]);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        check({tag, "_T_busy"}, sweep_busy, 1'b0);
        check({tag, "_T_ready"}, cfg_ready, 1'b0);
        check({tag, "_T_state"}, dbg_state, 1'b1);
        for (int k = 0; k < TT_W; k++) begin
            if (noisy) begin
                cfg_valid   = 1'b1;
                cfg_sel     = 2'd0;
                cfg_table   = 8'h00;
                in_valid    = 1'b1;
                in_vec      = 3'd0;
                sweep_start = 1'b1;
            end
            tick();
            exp_v = exp_q.pop_front();
`ifdef SWEEP_SIG_EN
            sig_exp = misr_step(sig_exp, exp_v);
`endif
            check($sformatf("%s_k%0d_valid", tag, k), out_valid, 1'b1);
            check($sformatf("%s_k%0d_idx", tag, k), out_idx, k[2:0]);
            check($sformatf("%s_k%0d_vec", tag, k), out_vec, exp_v);
            check($sformatf("%s_k%0d_busy", tag, k), sweep_busy, 1'b1);
            check($sformatf("%s_k%0d_done", tag, k), sweep_done, (k == TT_W - 1) ? 1'b1 : 1'b0);
        end
        cfg_valid   = 1'b0;
        in_valid    = 1'b0;
        sweep_start = 1'b0;
`ifdef SWEEP_SIG_EN
        check({tag, "_sig"}, sig, sig_exp);
`endif
        check({tag, "_end_ready"}, cfg_ready, 1'b1);
        tick();
        check({tag, "_after_busy"}, sweep_busy, 1'b0);
        check({tag, "_after_valid"}, out_valid, 1'b0);
        check({tag, "_after_done"}, sweep_done, 1'b0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Reset values while reset is held.
        #1;
        check_reset_outputs("rst0");
        tick();
        rst_n = 1'b1;
        check("rst0_ready_rel", cfg_ready, 1'b1);

        // 1. Reset in the middle of a sweep, then verify that the tables were cleared.
        load(2'd0, 8'hFF);
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t1_rst");
        tick();
        rst_n = 1'b1;
        eval("t1_eval7", 3'b111, 3'b000);

        // 2. Load the standard tables, then run a single eval and back-to-back evals.
        load(2'd0, 8'hE8);
        load(2'd1, 8'h96);
        load(2'd2, 8'h80);
        eval("t2_eval5", 3'b101, 3'b001);
        tick();
        check("t2_hold_valid", out_valid, 1'b0);
        check("t2_hold_vec", out_vec, 3'b001);
        check("t2_hold_idx", out_idx, 3'd5);
        eval("t2_b2b_a", 3'b011, 3'b001);
        eval("t2_b2b_b", 3'b100, 3'b010);
        eval("t2_b2b_c", 3'b111, 3'b111);

        // 3. Plain sweep.
        run_sweep("t3", 1'b0);
`ifdef SWEEP_SIG_EN
        sig_first = sig;
        check("t3_sig_hold", sig, sig_first == 16'h0000 ? 16'hFFFF : sig_first);
`endif

        // 4. Sweep with requests held high throughout.
        run_sweep("t4", 1'b1);
        eval("t4_eval7", 3'b111, 3'b111);

        // 5. A cfg write beats sweep_start in the same cycle.
        cfg_valid   = 1'b1;
        cfg_sel     = 2'd0;
        cfg_table   = 8'h01;
        sweep_start = 1'b1;
        tick();
        cfg_valid   = 1'b0;
        sweep_start = 1'b0;
        check("t5_no_sweep_ready", cfg_ready, 1'b1);
        check("t5_no_sweep_state", dbg_state, 1'b0);
        tick();
        check("t5_no_sweep_busy", sweep_busy, 1'b0);
        check("t5_no_sweep_valid", out_valid, 1'b0);
        eval("t5_eval0", 3'b000, 3'b001);
        eval("t5_eval7", 3'b111, 3'b110);
        // 5b. An out-of-range cfg_sel is discarded.
        load(2'd3, 8'hFF);
        eval("t5_oor_eval0", 3'b000, 3'b001);
        eval("t5_oor_eval6", 3'b110, 3'b000);
        load(2'd0, 8'hE8);

        // 6. Reset at sweep index 4.
        sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        repeat (5) tick();
        check("t6_at_idx4", out_idx, 3'd4);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        tick();
        rst_n = 1'b1;
        eval("t6_eval7", 3'b111, 3'b000);

`ifdef SWEEP_SIG_EN
        // Rerun the sweep twice on reloaded tables and check that the signatures match.
        load(2'd0, 8'hE8);
        load(2'd1, 8'h96);
        load(2'd2, 8'h80);
        run_sweep("t6_sigA", 1'b0);
        check("t6_sigA_vs_t3", sig, sig_first);
        run_sweep("t6_sigB", 1'b0);
        check("t6_sigB_vs_t3", sig, sig_first);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
